// File: rtl/usb_link_pkg.sv
// Shared USB link-layer definitions: CRC16 constants, receive-state encoding
// and the byte-wise reflected CRC16 update.
package usb_link_pkg;

  localparam logic [15:0] CRC16_INIT       = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R     = 16'hA001;
  localparam logic [15:0] CRC16_RESIDUAL_R = 16'hB001;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_RECV,
    RX_DROP
  } rx_state_e;

  // One byte into a reflected CRC16, data consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_R) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_rx_ring.sv
// Circular packet store: speculative write pointer, commit pointer that marks
// the end of the last good packet, and the consumer-side read stream.
module usb_rx_ring #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     wr_eop,
  input  logic                     commit,
  input  logic                     rewind,
  output logic                     full,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  output logic                     rd_sop,
  output logic                     rd_eop,
  output logic [$clog2(DEPTH):0]   pkt_pending
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] ONE = PTR_W'(1);

  logic [8:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [8:0]       rd_word;
  logic             sop_armed;
  logic             rd_fire;

  assign rd_word  = mem[rd_ptr[ADDR_W-1:0]];
  assign rd_valid = rd_ptr != commit_ptr;
  assign rd_data  = rd_word[7:0];
  assign rd_eop   = rd_valid & rd_word[8];
  assign rd_sop   = rd_valid & sop_armed;
  assign rd_fire  = rd_valid & rd_ready;
  assign full     = (wr_ptr - rd_ptr) == PTR_W'(DEPTH);

  // NOTE: storage has no reset; every entry is written before rd_valid can expose it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= {wr_eop, wr_data};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      rd_ptr      <= '0;
      sop_armed   <= 1'b1;
      pkt_pending <= '0;
    end else begin
      if (rewind)     wr_ptr <= commit_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + ONE;

      // Commit always accompanies the write of the packet's last byte.
      if (commit) commit_ptr <= wr_ptr + ONE;

      if (rd_fire) begin
        rd_ptr    <= rd_ptr + ONE;
        sop_armed <= rd_word[8];
      end

      unique case ({commit, rd_fire & rd_eop})
        2'b10:   pkt_pending <= pkt_pending + 1'b1;
        2'b01:   pkt_pending <= pkt_pending - 1'b1;
        default: pkt_pending <= pkt_pending;
      endcase
    end
  end

endmodule

// File: rtl/usb_rx_pkt_buf.sv
// Store-and-forward USB data-packet receiver: checks CRC16, strips the CRC
// bytes and releases only good, in-range packets from the ring buffer.
module usb_rx_pkt_buf
  import usb_link_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int MAX_LEN = 1025
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_data_on,
  input  logic                   rx_sop,
  input  logic                   rx_eop,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   rx_lt_sop,
  output logic                   rx_lt_eop,
  output logic                   rx_lt_valid,
  input  logic                   rx_lt_ready,
  output logic [7:0]             rx_lt_data,
  output logic                   rx_sop_en,
  output logic                   rx_lt_eop_en,
  output logic                   crc16_err,
  output logic                   len_err,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] pkt_pending
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  rx_state_e        state, state_n;
  logic [7:0]       hold0, hold0_n, hold1, hold1_n;
  logic             hold_full, hold_full_n;
  logic [CNT_W-1:0] wr_cnt, wr_cnt_n;
  logic [15:0]      crc, crc_n, crc_next;
  logic             beat, full;
  logic             wr_en, wr_eop, commit, rewind;
  logic             sop_p, crc_p, len_p, ovf_p;

  assign rx_ready = 1'b1;
  assign beat     = rx_valid & rx_data_on;
  assign crc_next = crc16_byte(crc, rx_data);

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_n     = state;
    hold0_n     = hold0;
    hold1_n     = hold1;
    hold_full_n = hold_full;
    wr_cnt_n    = wr_cnt;
    crc_n       = crc;
    wr_en       = 1'b0;
    wr_eop      = 1'b0;
    commit      = 1'b0;
    rewind      = 1'b0;
    sop_p       = 1'b0;
    crc_p       = 1'b0;
    len_p       = 1'b0;
    ovf_p       = 1'b0;

    if (beat && rx_sop) begin
      // A sop in any state starts afresh; a partial packet is discarded silently.
      rewind      = state != RX_IDLE;
      sop_p       = 1'b1;
      hold0_n     = rx_data;
      hold_full_n = 1'b0;
      wr_cnt_n    = '0;
      crc_n       = CRC16_INIT;
      if (rx_eop) begin
        len_p   = 1'b1;
        state_n = RX_IDLE;
      end else begin
        state_n = RX_RECV;
      end
    end else begin
      unique case (state)
        RX_RECV: begin
          if (!rx_data_on) begin
            state_n = RX_IDLE;
            rewind  = 1'b1;
          end else if (rx_valid) begin
            crc_n       = crc_next;
            hold0_n     = hold_full ? hold1 : hold0;
            hold1_n     = rx_data;
            hold_full_n = 1'b1;
            if (hold_full && full) begin
              ovf_p   = 1'b1;
              rewind  = 1'b1;
              state_n = rx_eop ? RX_IDLE : RX_DROP;
            end else if (hold_full && wr_cnt == MAX_CNT) begin
              len_p   = 1'b1;
              rewind  = 1'b1;
              state_n = rx_eop ? RX_IDLE : RX_DROP;
            end else begin
              wr_en    = hold_full;
              wr_cnt_n = wr_cnt + CNT_W'(hold_full);
              if (rx_eop) begin
                state_n = RX_IDLE;
                if (!hold_full) begin
                  len_p  = 1'b1;
                  rewind = 1'b1;
                end else if (crc_next == CRC16_RESIDUAL_R) begin
                  commit = 1'b1;
                  wr_eop = 1'b1;
                end else begin
                  crc_p  = 1'b1;
                  rewind = 1'b1;
                end
              end
            end
          end
        end
        RX_DROP: if (beat && rx_eop) state_n = RX_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RX_IDLE;
      hold0        <= '0;
      hold1        <= '0;
      hold_full    <= 1'b0;
      wr_cnt       <= '0;
      crc          <= CRC16_INIT;
      rx_sop_en    <= 1'b0;
      rx_lt_eop_en <= 1'b0;
      crc16_err    <= 1'b0;
      len_err      <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      state        <= state_n;
      hold0        <= hold0_n;
      hold1        <= hold1_n;
      hold_full    <= hold_full_n;
      wr_cnt       <= wr_cnt_n;
      crc          <= crc_n;
      rx_sop_en    <= sop_p;
      rx_lt_eop_en <= commit;
      crc16_err    <= crc_p;
      len_err      <= len_p;
      ovf          <= ovf_p;
    end
  end

  usb_rx_ring #(.DEPTH(DEPTH)) u_ring (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (hold0),
    .wr_eop      (wr_eop),
    .commit      (commit),
    .rewind      (rewind),
    .full        (full),
    .rd_ready    (rx_lt_ready),
    .rd_valid    (rx_lt_valid),
    .rd_data     (rx_lt_data),
    .rd_sop      (rx_lt_sop),
    .rd_eop      (rx_lt_eop),
    .pkt_pending (pkt_pending)
  );

endmodule

// File: tb/tb_usb_rx_pkt_buf.sv
// Directed bench for usb_rx_pkt_buf: scoreboard of expected output beats,
// pulse counters and immediate-assertion checks.
module tb_usb_rx_pkt_buf;

  localparam int DEPTH   = 32;
  localparam int MAX_LEN = 20;
  localparam int PW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_data_on = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0, rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_lt_ready = 1'b0;
  logic          rx_ready, rx_lt_sop, rx_lt_eop, rx_lt_valid;
  logic [7:0]    rx_lt_data;
  logic          rx_sop_en, rx_lt_eop_en, crc16_err, len_err, ovf;
  logic [PW-1:0] pkt_pending;

  int checks = 0, errors = 0;
  int n_sop = 0, n_eop_en = 0, n_crc = 0, n_len = 0, n_ovf = 0;
  int e_sop = 0, e_eop_en = 0, e_crc = 0, e_len = 0, e_ovf = 0;
  logic [9:0] exp_q[$];   // {sop, eop, data}
  logic [7:0] pl[$];
  logic       held = 1'b0;
  logic [9:0] held_word;

  usb_rx_pkt_buf #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .rx_data_on(rx_data_on), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .rx_lt_sop(rx_lt_sop),
    .rx_lt_eop(rx_lt_eop), .rx_lt_valid(rx_lt_valid), .rx_lt_ready(rx_lt_ready),
    .rx_lt_data(rx_lt_data), .rx_sop_en(rx_sop_en), .rx_lt_eop_en(rx_lt_eop_en),
    .crc16_err(crc16_err), .len_err(len_err), .ovf(ovf), .pkt_pending(pkt_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC: feedback is crc LSB xor data bit.
  function automatic logic [15:0] m_crc(input logic [15:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  // Output monitor: scoreboard pops, stall stability, pulse counts.
  always @(negedge clk) begin
    logic [9:0] w;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (rx_sop_en)    n_sop++;
      if (rx_lt_eop_en) n_eop_en++;
      if (crc16_err)    n_crc++;
      if (len_err)      n_len++;
      if (ovf)          n_ovf++;
      if (held) check("stall_stable", {rx_lt_valid, rx_lt_sop, rx_lt_eop, rx_lt_data}, {1'b1, held_word});
      held      = rx_lt_valid && !rx_lt_ready;
      held_word = {rx_lt_sop, rx_lt_eop, rx_lt_data};
      if (rx_lt_valid && rx_lt_ready) begin
        check("q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("out_beat", {rx_lt_sop, rx_lt_eop, rx_lt_data}, w);
        end
      end
    end
  end

  task automatic beat(input logic sop, input logic eop, input logic on, input logic [7:0] d);
    rx_valid = 1'b1; rx_sop = sop; rx_eop = eop; rx_data_on = on; rx_data = d;
    if (sop && on) e_sop++;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
  endtask

  task automatic fill_pl(input int n, input logic [7:0] base);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(base + 8'(i));
  endtask

  task automatic send_pkt(input logic [7:0] pid, input logic push);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < pl.size(); i++) c = m_crc(c, pl[i]);
    c = ~c;
    if (push) begin
      exp_q.push_back({1'b1, pl.size() == 0, pid});
      for (int i = 0; i < pl.size(); i++) exp_q.push_back({1'b0, i == pl.size() - 1, pl[i]});
    end
    beat(1'b1, 1'b0, 1'b1, pid);
    for (int i = 0; i < pl.size(); i++) beat(1'b0, 1'b0, 1'b1, pl[i]);
    beat(1'b0, 1'b0, 1'b1, c[7:0]);
    beat(1'b0, 1'b1, 1'b1, c[15:8]);
  endtask

  task automatic drain(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {rx_ready, rx_lt_valid, rx_lt_sop, rx_lt_eop, rx_sop_en, rx_lt_eop_en,
                crc16_err, len_err, ovf, 26'(pkt_pending)}, {9'b1_0000_0000, 26'd0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_values");
    rst = 1'b0;

    // Zero-length packet, consumer initially stalled to observe pkt_pending.
    exp_q.push_back({1'b1, 1'b1, 8'hC3});
    beat(1'b1, 1'b0, 1'b1, 8'hC3);
    check("sop_en_pulse", rx_sop_en, 1);
    beat(1'b0, 1'b0, 1'b1, 8'h00);
    beat(1'b0, 1'b1, 1'b1, 8'h00);
    e_eop_en++;
    check("zlp_eop_en", rx_lt_eop_en, 1);
    check("zlp_valid", rx_lt_valid, 1);
    check("zlp_pending1", pkt_pending, 1);
    check("zlp_word", {rx_lt_sop, rx_lt_eop, rx_lt_data}, {2'b11, 8'hC3});
    @(posedge clk); #1;
    check("eop_en_one_cycle", rx_lt_eop_en, 0);
    rx_lt_ready = 1'b1;
    drain("zlp_drain", 20);
    check("zlp_pending0", {rx_lt_valid, 7'(pkt_pending)}, 0);

    // Bad CRC.
    beat(1'b1, 1'b0, 1'b1, 8'hC3);
    beat(1'b0, 1'b0, 1'b1, 8'h00);
    beat(1'b0, 1'b1, 1'b1, 8'h01);
    e_crc++;
    check("crc_err_pulse", crc16_err, 1);
    repeat (3) @(posedge clk);
    #1;
    check("crc_nothing_out", {rx_lt_valid, 7'(pkt_pending)}, 0);

    // Back-pressure with two queued packets, then an overflowing third.
    rx_lt_ready = 1'b0;
    fill_pl(8, 8'h00);
    send_pkt(8'h4B, 1'b1);
    send_pkt(8'hC3, 1'b1);
    e_eop_en += 2;
    repeat (30) @(posedge clk);
    #1;
    check("bp_pending2", pkt_pending, 2);
    fill_pl(19, 8'h40);
    send_pkt(8'h4B, 1'b0);
    e_ovf++;
    repeat (2) @(posedge clk);
    #1;
    check("ovf_pending2", pkt_pending, 2);
    rx_lt_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      check("bp_no_bubble", rx_lt_valid, 1);
      @(posedge clk); #1;
    end
    check("bp_empty", {rx_lt_valid, 7'(pkt_pending)}, 0);
    check("bp_all_out", exp_q.size(), 0);

    // Length limits: exactly MAX_LEN stored bytes pass, one more is dropped.
    fill_pl(MAX_LEN - 1, 8'h80);
    send_pkt(8'hD2, 1'b1);
    e_eop_en++;
    drain("max_len_drain", 40);
    fill_pl(MAX_LEN, 8'h90);
    send_pkt(8'hD2, 1'b0);
    e_len++;
    check("len_long_pulse", len_err, 1);
    repeat (3) @(posedge clk);
    #1;
    check("len_long_nothing", {rx_lt_valid, 7'(pkt_pending)}, 0);

    // Abort by rx_data_on, ignored beats in IDLE, restart by a new sop.
    beat(1'b1, 1'b0, 1'b1, 8'hC3);
    beat(1'b0, 1'b0, 1'b1, 8'h11);
    beat(1'b0, 1'b0, 1'b0, 8'h22);
    beat(1'b0, 1'b0, 1'b1, 8'h33);
    beat(1'b1, 1'b0, 1'b1, 8'h69);
    beat(1'b0, 1'b0, 1'b1, 8'h01);
    beat(1'b0, 1'b0, 1'b1, 8'h02);
    exp_q.push_back({1'b1, 1'b1, 8'hC3});
    beat(1'b1, 1'b0, 1'b1, 8'hC3);
    beat(1'b0, 1'b0, 1'b1, 8'h00);
    beat(1'b0, 1'b1, 1'b1, 8'h00);
    e_eop_en++;
    drain("abort_zlp_drain", 20);
    beat(1'b1, 1'b0, 1'b1, 8'hC3);
    beat(1'b0, 1'b1, 1'b1, 8'h00);
    e_len++;
    check("short_len_pulse", len_err, 1);

    // Reset in the middle of delivery.
    rx_lt_ready = 1'b0;
    fill_pl(6, 8'hA0);
    send_pkt(8'h4B, 1'b1);
    e_eop_en++;
    rx_lt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset_mid_delivery");
    exp_q.delete();
    rst = 1'b0;
    fill_pl(0, 8'h00);
    send_pkt(8'hC3, 1'b1);
    e_eop_en++;
    drain("post_reset_zlp", 20);
    check("final_pending", {rx_lt_valid, 7'(pkt_pending)}, 0);

    check("count_sop_en", n_sop, e_sop);
    check("count_eop_en", n_eop_en, e_eop_en);
    check("count_crc_err", n_crc, e_crc);
    check("count_len_err", n_len, e_len);
    check("count_ovf", n_ovf, e_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
